// File: rtl/multi_issue_decode_pkg.sv
// Shared types for the multi-issue decode stage: opcode set, decoded task
// record, control-select enums and a lane popcount helper.
package multi_issue_decode_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_NOP    = 7'b0001111,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_fun_t;

  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} op_a_sel_t;
  typedef enum logic [1:0] {OPB_RS2, OPB_IMM_I, OPB_IMM_S, OPB_IMM_U} op_b_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_NONE} wb_sel_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_used;
    logic        rs1_used;
    logic        rs2_used;
    alu_fun_t    alu_fun;
    op_a_sel_t   op_a_sel;
    op_b_sel_t   op_b_sel;
    wb_sel_t     wb_sel;
    logic [2:0]  mem_type;
    logic [31:0] i_immed;
    logic [31:0] s_immed;
    logic [31:0] u_immed;
    logic [31:0] pc;
  } task_t;

  // Number of set bits; used to advance the sequence counter per bundle.
  function automatic logic [3:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/multi_issue_decode_lane.sv
// One decode lane: purely combinational instruction word + pc -> task_t,
// plus an illegal flag for opcodes outside opcode_t.
module multi_issue_decode_lane
  import multi_issue_decode_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  output task_t       decoded,
  output logic        illegal
);

  opcode_t opc;
  assign opc = opcode_t'(ir[6:0]);

  function automatic alu_fun_t alu_decode(input logic [2:0] f3, input logic f7, input logic is_op);
    alu_fun_t f;
    case (f3)
      3'd0:    f = (is_op && f7) ? ALU_SUB : ALU_ADD;
      3'd1:    f = ALU_SLL;
      3'd2:    f = ALU_SLT;
      3'd3:    f = ALU_SLTU;
      3'd4:    f = ALU_XOR;
      3'd5:    f = f7 ? ALU_SRA : ALU_SRL;
      3'd6:    f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

  // Control-unit decode; field extraction is unconditional, usage flags per opcode.
  always_comb begin
    decoded          = '0;
    illegal          = 1'b0;
    decoded.rd_addr  = ir[11:7];
    decoded.rs1_addr = ir[19:15];
    decoded.rs2_addr = ir[24:20];
    decoded.mem_type = ir[14:12];
    decoded.i_immed  = {{20{ir[31]}}, ir[31:20]};
    decoded.s_immed  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    decoded.u_immed  = {ir[31:12], 12'h000};
    decoded.pc       = pc;
    decoded.alu_fun  = ALU_ADD;
    decoded.op_a_sel = OPA_RS1;
    decoded.op_b_sel = OPB_RS2;
    decoded.wb_sel   = WB_ALU;
    case (opc)
      OPC_LUI: begin
        decoded.rd_used  = 1'b1;
        decoded.op_a_sel = OPA_ZERO;
        decoded.op_b_sel = OPB_IMM_U;
      end
      OPC_AUIPC: begin
        decoded.rd_used  = 1'b1;
        decoded.op_a_sel = OPA_PC;
        decoded.op_b_sel = OPB_IMM_U;
      end
      OPC_JAL: begin
        decoded.rd_used  = 1'b1;
        decoded.op_a_sel = OPA_PC;
        decoded.wb_sel   = WB_PC4;
      end
      OPC_JALR: begin
        decoded.rd_used  = 1'b1;
        decoded.rs1_used = 1'b1;
        decoded.op_b_sel = OPB_IMM_I;
        decoded.wb_sel   = WB_PC4;
      end
      OPC_BRANCH: begin
        decoded.rs1_used = 1'b1;
        decoded.rs2_used = 1'b1;
        decoded.alu_fun  = ALU_SUB;
        decoded.wb_sel   = WB_NONE;
      end
      OPC_LOAD: begin
        decoded.rd_used  = 1'b1;
        decoded.rs1_used = 1'b1;
        decoded.op_b_sel = OPB_IMM_I;
        decoded.wb_sel   = WB_MEM;
      end
      OPC_STORE: begin
        decoded.rs1_used = 1'b1;
        decoded.rs2_used = 1'b1;
        decoded.op_b_sel = OPB_IMM_S;
        decoded.wb_sel   = WB_NONE;
      end
      OPC_OP_IMM: begin
        decoded.rd_used  = 1'b1;
        decoded.rs1_used = 1'b1;
        decoded.op_b_sel = OPB_IMM_I;
        decoded.alu_fun  = alu_decode(ir[14:12], ir[30], 1'b0);
      end
      OPC_OP: begin
        decoded.rd_used  = 1'b1;
        decoded.rs1_used = 1'b1;
        decoded.rs2_used = 1'b1;
        decoded.alu_fun  = alu_decode(ir[14:12], ir[30], 1'b1);
      end
      OPC_NOP: begin
        decoded.wb_sel = WB_NONE;
      end
      default: begin
        illegal        = 1'b1;
        decoded.wb_sel = WB_NONE;
      end
    endcase
  end

endmodule

// File: rtl/multi_issue_decode.sv
// N-wide registered decode stage with program-order sequence tagging.
// Optional DECODE_SKID_EN adds a one-bundle skid buffer so that if_ready is
// driven from a register instead of combinationally from dec_ready.
module multi_issue_decode
  import multi_issue_decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int SEQ_W = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic [SEQ_W-1:0]       flush_seq,
  input  logic                   if_valid,
  input  logic [WIDTH-1:0]       if_lane_valid,
  input  logic [WIDTH*32-1:0]    if_pc,
  input  logic [WIDTH*32-1:0]    if_ir,
  output logic                   if_ready,
  output logic                   dec_valid,
  output logic [WIDTH-1:0]       dec_lane_valid,
  output task_t [WIDTH-1:0]      dec_task,
  output logic [WIDTH*SEQ_W-1:0] dec_seq,
  output logic [WIDTH-1:0]       dec_illegal,
  input  logic                   dec_ready
);

  task_t [WIDTH-1:0]      lane_task;
  logic  [WIDTH-1:0]      lane_illegal;
  task_t [WIDTH-1:0]      stamp_task;
  logic  [WIDTH*SEQ_W-1:0] stamp_seq;
  logic  [WIDTH-1:0]      stamp_illegal;
  logic  [SEQ_W-1:0]      seq_count;
  logic  [3:0]            lane_count;
  logic                   accept;
  logic                   load_any;
  logic                   out_free;

  // Lanes are contiguous from lane 0, so lane i's tag is simply counter + i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    multi_issue_decode_lane u_lane (
      .ir      (if_ir[i*32 +: 32]),
      .pc      (if_pc[i*32 +: 32]),
      .decoded (lane_task[i]),
      .illegal (lane_illegal[i])
    );
    assign stamp_task[i]                 = if_lane_valid[i] ? lane_task[i] : '0;
    assign stamp_illegal[i]              = if_lane_valid[i] & lane_illegal[i];
    assign stamp_seq[i*SEQ_W +: SEQ_W]   = if_lane_valid[i] ? seq_count + SEQ_W'(i) : '0;
  end

  assign lane_count = popcount(MAX_WIDTH'(if_lane_valid));
  assign accept     = if_valid & if_ready;
  assign load_any   = accept & (|if_lane_valid);
  assign out_free   = !dec_valid | dec_ready;

  // Sequence counter: flush reloads it, an accepted non-empty bundle advances it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           seq_count <= '0;
    else if (flush)    seq_count <= flush_seq;
    else if (load_any) seq_count <= seq_count + SEQ_W'(lane_count);
  end

`ifdef DECODE_SKID_EN
  logic                    skid_valid;
  logic [WIDTH-1:0]        skid_lane_valid;
  task_t [WIDTH-1:0]       skid_task;
  logic [WIDTH*SEQ_W-1:0]  skid_seq;
  logic [WIDTH-1:0]        skid_illegal;

  // skid_valid is a flop; flush only blocks the input during its own cycle.
  assign if_ready = !skid_valid & !flush;

  // Output slot and skid slot; skid drains into the output before new input is taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || flush) begin
      dec_valid       <= 1'b0;
      dec_lane_valid  <= '0;
      dec_task        <= '0;
      dec_seq         <= '0;
      dec_illegal     <= '0;
      skid_valid      <= 1'b0;
      skid_lane_valid <= '0;
      skid_task       <= '0;
      skid_seq        <= '0;
      skid_illegal    <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        dec_valid       <= 1'b1;
        dec_lane_valid  <= skid_lane_valid;
        dec_task        <= skid_task;
        dec_seq         <= skid_seq;
        dec_illegal     <= skid_illegal;
        skid_valid      <= 1'b0;
        skid_lane_valid <= '0;
        skid_task       <= '0;
        skid_seq        <= '0;
        skid_illegal    <= '0;
      end else if (load_any) begin
        dec_valid      <= 1'b1;
        dec_lane_valid <= if_lane_valid;
        dec_task       <= stamp_task;
        dec_seq        <= stamp_seq;
        dec_illegal    <= stamp_illegal;
      end else begin
        dec_valid      <= 1'b0;
        dec_lane_valid <= '0;
        dec_task       <= '0;
        dec_seq        <= '0;
        dec_illegal    <= '0;
      end
    end else if (load_any) begin
      skid_valid      <= 1'b1;
      skid_lane_valid <= if_lane_valid;
      skid_task       <= stamp_task;
      skid_seq        <= stamp_seq;
      skid_illegal    <= stamp_illegal;
    end
  end
`else
  assign if_ready = !flush & out_free;

  // Single output slot: load on accept, clear when drained, hold while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || flush) begin
      dec_valid      <= 1'b0;
      dec_lane_valid <= '0;
      dec_task       <= '0;
      dec_seq        <= '0;
      dec_illegal    <= '0;
    end else if (load_any) begin
      dec_valid      <= 1'b1;
      dec_lane_valid <= if_lane_valid;
      dec_task       <= stamp_task;
      dec_seq        <= stamp_seq;
      dec_illegal    <= stamp_illegal;
    end else if (out_free) begin
      dec_valid      <= 1'b0;
      dec_lane_valid <= '0;
      dec_task       <= '0;
      dec_seq        <= '0;
      dec_illegal    <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_multi_issue_decode.sv
// Directed bench for multi_issue_decode (WIDTH=2, SEQ_W=6); expectations
// follow DECODE_SKID_EN where the two builds differ.
module tb_multi_issue_decode;
  import multi_issue_decode_pkg::*;

  localparam logic [31:0] IR_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] IR_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] IR_SUB  = 32'h402082B3; // sub  x5,x1,x2
  localparam logic [31:0] IR_BAD  = 32'h0000007F;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic [5:0]  flush_seq = '0;
  logic        if_valid = 1'b0;
  logic [1:0]  if_lane_valid = '0;
  logic [63:0] if_pc = '0;
  logic [63:0] if_ir = '0;
  logic        if_ready;
  logic        dec_valid;
  logic [1:0]  dec_lane_valid;
  task_t [1:0] dec_task;
  logic [11:0] dec_seq;
  logic [1:0]  dec_illegal;
  logic        dec_ready = 1'b1;

  int total = 0;
  int bad = 0;

  multi_issue_decode #(.WIDTH(2), .SEQ_W(6)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .flush_seq(flush_seq),
    .if_valid(if_valid), .if_lane_valid(if_lane_valid), .if_pc(if_pc), .if_ir(if_ir),
    .if_ready(if_ready), .dec_valid(dec_valid), .dec_lane_valid(dec_lane_valid),
    .dec_task(dec_task), .dec_seq(dec_seq), .dec_illegal(dec_illegal), .dec_ready(dec_ready)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] ir0, input logic [31:0] ir1);
    if_valid      = v;
    if_lane_valid = lv;
    if_ir         = {ir1, ir0};
    if_pc         = {32'h0000_0104, 32'h0000_0100};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", dec_valid); end
    total++; if (dec_lane_valid !== 2'b00) begin bad++; $display("FAIL rst_lane_valid got=%0h exp=0", dec_lane_valid); end
    total++; if (dec_seq !== 12'h000) begin bad++; $display("FAIL rst_seq got=%0h exp=0", dec_seq); end
    total++; if (dec_task !== '0) begin bad++; $display("FAIL rst_task got=%0h exp=0", dec_task); end
    total++; if (dec_illegal !== 2'b00) begin bad++; $display("FAIL rst_illegal got=%0h exp=0", dec_illegal); end
    #2 RST = 1'b0;
    #1;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_if_ready got=%0h exp=1", if_ready); end
    tick();
  endtask

  task automatic test_basic();
    dec_ready = 1'b1;
    drive(1'b1, 2'b11, IR_ADDI, IR_ADD);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h exp=1", dec_valid); end
    total++; if (dec_lane_valid !== 2'b11) begin bad++; $display("FAIL basic_lane_valid got=%0h exp=3", dec_lane_valid); end
    total++; if (dec_seq !== {6'd1, 6'd0}) begin bad++; $display("FAIL basic_seq got=%0h exp=%0h", dec_seq, {6'd1, 6'd0}); end
    total++; if (dec_task[0].rs2_used !== 1'b0) begin bad++; $display("FAIL basic_t0_rs2_used got=%0h exp=0", dec_task[0].rs2_used); end
    total++; if (dec_task[0].i_immed !== 32'd5) begin bad++; $display("FAIL basic_t0_immed got=%0h exp=5", dec_task[0].i_immed); end
    total++; if (dec_task[0].rd_addr !== 5'd1 || dec_task[0].op_b_sel !== OPB_IMM_I) begin bad++; $display("FAIL basic_t0_rd_opb got=%0h/%0h exp=1/1", dec_task[0].rd_addr, dec_task[0].op_b_sel); end
    total++; if (dec_task[1].rs2_used !== 1'b1) begin bad++; $display("FAIL basic_t1_rs2_used got=%0h exp=1", dec_task[1].rs2_used); end
    total++; if (dec_task[1].rd_addr !== 5'd3) begin bad++; $display("FAIL basic_t1_rd got=%0h exp=3", dec_task[1].rd_addr); end
    total++; if (dec_task[1].pc !== 32'h104 || dec_task[1].alu_fun !== ALU_ADD) begin bad++; $display("FAIL basic_t1_pc_alu got=%0h/%0h exp=104/0", dec_task[1].pc, dec_task[1].alu_fun); end
    total++; if (dec_illegal !== 2'b00) begin bad++; $display("FAIL basic_illegal got=%0h exp=0", dec_illegal); end
    tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0h exp=0", dec_valid); end
  endtask

  // Output holds A (tags 2,3) while B is offered during a two-cycle stall.
  task automatic test_stall();
    dec_ready = 1'b1;
    drive(1'b1, 2'b11, IR_ADDI, IR_ADD);
    tick();
    dec_ready = 1'b0;
    drive(1'b1, 2'b11, IR_ADDI, IR_SUB);
    #1;
`ifdef DECODE_SKID_EN
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL stall_if_ready0 got=%0h exp=1", if_ready); end
`else
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL stall_if_ready0 got=%0h exp=0", if_ready); end
`endif
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (dec_seq !== {6'd3, 6'd2}) begin bad++; $display("FAIL stall_seq c=%0d got=%0h exp=%0h", c, dec_seq, {6'd3, 6'd2}); end
      total++; if (dec_valid !== 1'b1 || dec_task[1].alu_fun !== ALU_ADD) begin bad++; $display("FAIL stall_hold c=%0d got=%0h/%0h exp=1/0", c, dec_valid, dec_task[1].alu_fun); end
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL stall_if_ready c=%0d got=%0h exp=0", c, if_ready); end
    end
    dec_ready = 1'b1;
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_seq !== {6'd5, 6'd4}) begin bad++; $display("FAIL stall_b_seq got=%0h exp=%0h", dec_seq, {6'd5, 6'd4}); end
    total++; if (dec_task[1].alu_fun !== ALU_SUB || dec_task[1].rd_addr !== 5'd5) begin bad++; $display("FAIL stall_b_task got=%0h/%0h exp=1/5", dec_task[1].alu_fun, dec_task[1].rd_addr); end
    tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0h exp=0", dec_valid); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; flush_seq = 6'd62;
    tick();
    flush = 1'b0;
    drive(1'b1, 2'b11, IR_ADDI, IR_ADD);
    tick();
    total++; if (dec_seq !== {6'd63, 6'd62}) begin bad++; $display("FAIL wrap_seq0 got=%0h exp=%0h", dec_seq, {6'd63, 6'd62}); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_seq !== {6'd1, 6'd0} || dec_valid !== 1'b1) begin bad++; $display("FAIL wrap_seq1 got=%0h v=%0h exp=%0h v=1", dec_seq, dec_valid, {6'd1, 6'd0}); end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b01, IR_BAD, IR_ADD);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_illegal !== 2'b01) begin bad++; $display("FAIL ill_flag got=%0h exp=1", dec_illegal); end
    total++; if (dec_lane_valid !== 2'b01) begin bad++; $display("FAIL ill_lane_valid got=%0h exp=1", dec_lane_valid); end
    total++; if (dec_task[1] !== '0) begin bad++; $display("FAIL ill_t1_zero got=%0h exp=0", dec_task[1]); end
    total++; if (dec_seq !== {6'd0, 6'd2}) begin bad++; $display("FAIL ill_seq got=%0h exp=%0h", dec_seq, {6'd0, 6'd2}); end
    total++; if ({dec_task[0].rd_used, dec_task[0].rs1_used, dec_task[0].rs2_used} !== 3'b000) begin bad++; $display("FAIL ill_used got=%0h exp=0", {dec_task[0].rd_used, dec_task[0].rs1_used, dec_task[0].rs2_used}); end
    tick();
    drive(1'b1, 2'b00, IR_ADDI, IR_ADD);
    tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%0h exp=0", dec_valid); end
    drive(1'b1, 2'b01, IR_ADDI, IR_ADD);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_seq !== {6'd0, 6'd3}) begin bad++; $display("FAIL empty_seq got=%0h exp=%0h", dec_seq, {6'd0, 6'd3}); end
    tick();
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    drive(1'b1, 2'b11, IR_ADDI, IR_ADD);
    tick();
    flush = 1'b1; flush_seq = 6'd17;
    #1;
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL flush_if_ready got=%0h exp=0", if_ready); end
    tick();
    flush = 1'b0;
    total++; if (dec_valid !== 1'b0 || dec_lane_valid !== 2'b00) begin bad++; $display("FAIL flush_clear got=%0h/%0h exp=0/0", dec_valid, dec_lane_valid); end
    dec_ready = 1'b1;
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_seq !== {6'd18, 6'd17}) begin bad++; $display("FAIL flush_seq got=%0h exp=%0h", dec_seq, {6'd18, 6'd17}); end
    tick();
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    drive(1'b1, 2'b11, IR_ADDI, IR_ADD);
    tick();
    total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0h exp=1", dec_valid); end
    #2 RST = 1'b1;
    #1;
    total++; if (dec_valid !== 1'b0 || dec_lane_valid !== 2'b00) begin bad++; $display("FAIL arst_clear got=%0h/%0h exp=0/0", dec_valid, dec_lane_valid); end
    #1 RST = 1'b0;
    dec_ready = 1'b1;
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (dec_seq !== {6'd1, 6'd0} || dec_valid !== 1'b1) begin bad++; $display("FAIL arst_seq got=%0h v=%0h exp=%0h v=1", dec_seq, dec_valid, {6'd1, 6'd0}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
